// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module  : hazard_scoreboard
// Brief   : D-stage RAW hazard scoreboard; tracks E/M/W write addresses and
//           Tnew, answers rs/rt queries with stall and forward selects.
//           Optional stall counter enabled by HAZARD_SB_STALL_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int TNEW_W = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              D_valid,
    input  logic [4:0]        D_WA,
    input  logic [TNEW_W-1:0] D_Tnew,
    input  logic [4:0]        D_A1,
    input  logic [4:0]        D_A2,
    input  logic              D_use_rs,
    input  logic              D_use_rt,
    input  logic [TNEW_W-1:0] D_Tuse_rs,
    input  logic [TNEW_W-1:0] D_Tuse_rt,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_rs,
    output logic [1:0]        fwd_rt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    logic [4:0]        e_wa;
    logic [TNEW_W-1:0] e_tnew;
    logic [4:0]        m_wa;
    logic [TNEW_W-1:0] m_tnew;
    // W's Tnew is always zero, so only its address is stored.
    logic [4:0]        w_wa;

    logic              stall_rs;
    logic              stall_rt;
    logic [TNEW_W-1:0] e_tnew_dec;

    function automatic logic src_stall(
        input logic              use_src,
        input logic [4:0]        a,
        input logic [TNEW_W-1:0] t,
        input logic [4:0]        ewa,
        input logic [TNEW_W-1:0] etn,
        input logic [4:0]        mwa,
        input logic [TNEW_W-1:0] mtn
    );
        return use_src && (a != 5'd0) &&
               (((ewa == a) && (etn > t)) || ((mwa == a) && (mtn > t)));
    endfunction

    // Youngest matching stage decides; a match still waiting on its result
    // yields RF here and is resolved by the later-stage forward units.
    function automatic logic [1:0] src_fwd(
        input logic              use_src,
        input logic [4:0]        a,
        input logic [4:0]        ewa,
        input logic [TNEW_W-1:0] etn,
        input logic [4:0]        mwa,
        input logic [TNEW_W-1:0] mtn,
        input logic [4:0]        wwa
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_src && (a != 5'd0)) begin
            if (ewa == a)
                sel = (etn == '0) ? FWD_E : FWD_RF;
            else if (mwa == a)
                sel = (mtn == '0) ? FWD_M : FWD_RF;
            else if (wwa == a)
                sel = FWD_W;
        end
        return sel;
    endfunction

    always_comb begin
        stall_rs   = src_stall(D_use_rs, D_A1, D_Tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
        stall_rt   = src_stall(D_use_rt, D_A2, D_Tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
        stall      = stall_rs | stall_rt;
        fwd_rs     = src_fwd(D_use_rs, D_A1, e_wa, e_tnew, m_wa, m_tnew, w_wa);
        fwd_rt     = src_fwd(D_use_rt, D_A2, e_wa, e_tnew, m_wa, m_tnew, w_wa);
        e_tnew_dec = (e_tnew == '0) ? '0 : e_tnew - TNEW_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_wa   <= '0;
            e_tnew <= '0;
            m_wa   <= '0;
            m_tnew <= '0;
            w_wa   <= '0;
        end else if (flush) begin
            e_wa   <= '0;
            e_tnew <= '0;
            m_wa   <= '0;
            m_tnew <= '0;
            w_wa   <= '0;
        end else begin
            // A stall holds D, so E receives a bubble; M and W keep advancing.
            if (D_valid && !stall) begin
                e_wa   <= D_WA;
                e_tnew <= D_Tnew;
            end else begin
                e_wa   <= '0;
                e_tnew <= '0;
            end
            m_wa   <= e_wa;
            m_tnew <= e_tnew_dec;
            w_wa   <= m_wa;
        end
    end

`ifdef HAZARD_SB_STALL_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Not cleared by flush: it measures stall cycles across the whole run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (stall && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + CNT_W'(1);
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire
